apb_slave_bank: RTL and testbench
=================================

# apb_slave_bank

Parametrised APB completer bank sitting on the APB side of the AHB-APB bridge. It replaces the pass-through stub peripheral with `NUM_SLAVES` real register-file slaves behind one shared APB bus. Each slave has `DEPTH` words of storage, and the bank supports programmable wait states through `pready` and error signalling through `pslverr`. It is the bridge's standard target for integration and regression.

## Interface
Parameters:
- `NUM_SLAVES`, 3: number of one-hot `pselx` lines and register files.
- `DATA_WIDTH`, 32: width of `pwdata` and `prdata`.
- `ADDR_WIDTH`, 32: width of `paddr`.
- `DEPTH`, 16: words per slave; power of two, at least 2.
- `WAIT_CYCLES`, 0: wait states inserted in every access phase, 0..15.

Ports (one clock; reset is asynchronous and active-low):
- `hclk`  in  1  bus clock, rising edge.
- `hresetn`  in  1  asynchronous active-low reset.
- `pselx`  in  `NUM_SLAVES`  one-hot slave select.
- `penable`  in  1  access-phase strobe.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `ADDR_WIDTH`  byte address.
- `pwdata`  in  `DATA_WIDTH`  write data.
- `prdata`  out  `DATA_WIDTH`  read data.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  transfer error; valid only when `pready`=1.

## Operation
- The FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter `wcnt`.
- **Setup capture.** In IDLE, a cycle with `|pselx`=1 and `penable`=0 is a setup cycle. At the edge that ends it, the block:
  - latches `pselx`, `paddr`, `pwrite` and `pwdata`;
  - loads `wcnt` with `WAIT_CYCLES`;
  - moves to ACCESS.
- **Stray enable.** In IDLE, `penable`=1 is ignored: no capture, and `pready` stays 0.
- **Access phase.** In ACCESS:
  - `pready` = (`wcnt`==0).
  - While `wcnt`!=0, `wcnt` decrements each cycle.
  - At the edge where `pready`=1, the transfer completes and the FSM returns to IDLE.
  - If the next cycle is a setup cycle, it is captured normally, so back-to-back transfers cost 2+`WAIT_CYCLES` cycles each.
- **Abort.** If `|pselx` drops to 0 in ACCESS before completion, the FSM goes to IDLE with no write and no response.
- **Word index.** The index is `paddr[log2(DEPTH)+1:2]`, using the latched address.
- **Error conditions.** An error is flagged when any of the following holds for the latched address or select:
  - `paddr[1:0]`!=0;
  - any `paddr` bit above `log2(DEPTH)+1` is set;
  - the latched `pselx` is not exactly one-hot.
- **Error response.** On error, `pslverr`=1 together with `pready`, no write occurs, and `prdata`=0.
- **Write.** `mem[sel][idx]` is updated with the latched `pwdata` at the completing edge, only if there is no error.
- **Read.** `prdata` = `mem[sel][idx]` during the `pready` cycle. `prdata` is 0 at all other times.
- Each slave's storage is independent; equal addresses in different slaves do not alias.

## Timing
- **Reset.** Asserting `hresetn` low immediately forces:
  - state = IDLE, `wcnt` = 0;
  - `pready`, `pslverr`, `prdata` = 0;
  - all memory words = 0.
- **Reset mid-transfer.** Reset during ACCESS abandons the transfer. A write in flight is not committed.
- **Latency.** The first access cycle is the cycle after setup. `pready` rises `WAIT_CYCLES` cycles after that; with `WAIT_CYCLES`=0 it is high in the first access cycle.
- **Output timing.** `pready`, `pslverr` and `prdata` are combinational from state, `wcnt`, the latched fields and memory, with no path from current-cycle inputs.
- **Write visibility.** Data written at edge N is readable by any read whose `pready` cycle is after edge N.

## Structure
- Shared package `apb_pkg`:
  - state enum `{APB_IDLE, APB_ACCESS}`;
  - `APB_WCNT_W`=4;
  - `apb_addr_err()` helper function.
- Sub-module `apb_regfile`: one slave's `DEPTH`x`DATA_WIDTH` storage with async clear, write enable and combinational read port. It is instantiated `NUM_SLAVES` times in a generate loop.
- The FSM, wait counter, decode and response mux live in the top module.

## Test plan
- Reset → all outputs 0. Then write 0xCAFE_0001 to slave 1 at 0x8 (`WAIT_CYCLES`=0), read it back → `prdata`=0xCAFE_0001, `pready` high in the first access cycle, `pslverr`=0.
- With `WAIT_CYCLES`=3, read slave 0 at 0x4 → `pready` low for 3 access cycles, high on the 4th with `prdata`=0.
- Write 0x1234 to 0x3 (misaligned), then write 0x5678 to 0x40 with `DEPTH`=16 → `pslverr`=1 for both, and a readback of word 0 returns 0.
- Set `pselx`=3'b011 during setup → `pslverr`=1 and no slave modified.
- Perform 4 back-to-back writes to slave 2 at 0x0/0x4/0x8/0xC, then read them back → values match, and each transfer takes exactly 2 cycles.
- Drop `pselx` in a wait cycle of a write, and separately assert `hresetn` low mid-ACCESS → target word unchanged; the reset case clears memory and outputs immediately.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, constants and address-check helper for the APB slave bank
// Purpose: FSM state encoding, wait-counter width and the address error check.
// Ports: none (package).
package apb_pkg;

    typedef enum logic {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_WCNT_W   = 4;
    localparam int APB_ADDR_MAX = 64;

    // Flags a misaligned address or any set bit at or above idx_top, where
    // idx_top is the first bit position beyond the word-index field.
    function automatic logic apb_addr_err(input logic [APB_ADDR_MAX-1:0] addr,
                                          input int                      idx_top);
        return (addr[1:0] != 2'b00) || ((addr >> idx_top) != '0);
    endfunction

endpackage

// File: rtl/apb_slave_bank_if.sv
// rtl/apb_slave_bank_if.sv - shared APB bus between requester and the slave bank
// Purpose: bundles the APB select/strobe/address/data and response signals.
// Ports (signals): pselx, penable, pwrite, paddr, pwdata (requester -> bank);
//                  prdata, pready, pslverr (bank -> requester).
interface apb_slave_bank_if #(
    parameter int NUM_SLAVES = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_SLAVES-1:0] pselx;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - one slave's word storage with async clear and combinational read
// Purpose: DEPTH x DATA_WIDTH register file for a single APB slave.
// Ports: clk_i, rst_ni (async clear of every word), we_i, addr_i (word index),
//        wdata_i, rdata_o (combinational read of addr_i).
module apb_regfile #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/apb_slave_bank.sv
// rtl/apb_slave_bank.sv - NUM_SLAVES APB register-file completers behind one shared bus
// Purpose: setup capture, wait-state counting, address/select error decode and
//          response mux in front of NUM_SLAVES apb_regfile instances.
// Ports: hclk, hresetn (async active-low), bus (apb_slave_bank_if.slave).
module apb_slave_bank
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES  = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               hclk,
    input  logic               hresetn,
    apb_slave_bank_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);

    apb_state_e              state_q, state_d;
    logic [APB_WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    setup;
    logic                    complete;
    logic                    ready;
    logic                    err;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   rd_slave [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]   rd_mux;

    assign setup = (state_q == APB_IDLE) && (|bus.pselx) && !bus.penable;
    assign ready = (state_q == APB_ACCESS) && (wcnt_q == '0);
    assign idx   = addr_q[IDX_W+1:2];
    // A select that is not one-hot is treated as an error rather than
    // broadcasting the write or OR-ing several read words together.
    assign err   = apb_addr_err(APB_ADDR_MAX'(addr_q), IDX_W + 2) || !$onehot(sel_q);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= APB_IDLE;
            wcnt_q  <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        complete = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (setup) begin
                    sel_d   = bus.pselx;
                    addr_d  = bus.paddr;
                    write_d = bus.pwrite;
                    wdata_d = bus.pwdata;
                    wcnt_d  = APB_WCNT_W'(WAIT_CYCLES);
                    state_d = APB_ACCESS;
                end
            end
            APB_ACCESS: begin
                // Losing the select before the ready edge abandons the
                // transfer, including a select dropped in the ready cycle.
                if (!(|bus.pselx)) begin
                    state_d = APB_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = APB_IDLE;
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
        apb_regfile #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_regfile (
            .clk_i   (hclk),
            .rst_ni  (hresetn),
            .we_i    (complete && write_q && !err && sel_q[g]),
            .addr_i  (idx),
            .wdata_i (wdata_q),
            .rdata_o (rd_slave[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | rd_slave[i];
            end
        end
    end

    assign bus.pready  = ready;
    assign bus.pslverr = ready && err;
    assign bus.prdata  = (ready && !err && !write_q) ? rd_mux : '0;
endmodule

// File: tb/tb_apb_slave_bank.sv
// tb/tb_apb_slave_bank.sv - directed self-checking bench for apb_slave_bank
module tb_apb_slave_bank;
    logic hclk;
    logic rst0_n;
    logic rst3_n;
    int   checks;
    int   errors;

    apb_slave_bank_if #(.NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
    apb_slave_bank_if #(.NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

    apb_slave_bank #(
        .NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)
    ) dut0 (
        .hclk    (hclk),
        .hresetn (rst0_n),
        .bus     (b0)
    );

    apb_slave_bank #(
        .NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(3)
    ) dut3 (
        .hclk    (hclk),
        .hresetn (rst3_n),
        .bus     (b3)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic drive(input bit w3, input logic [2:0] sel, input logic en,
                         input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (w3) begin
            b3.pselx = sel; b3.penable = en; b3.pwrite = wr; b3.paddr = a; b3.pwdata = d;
        end else begin
            b0.pselx = sel; b0.penable = en; b0.pwrite = wr; b0.paddr = a; b0.pwdata = d;
        end
    endtask

    task automatic sample(input bit w3, output logic rdy, output logic er, output logic [31:0] rd);
        if (w3) begin
            rdy = b3.pready; er = b3.pslverr; rd = b3.prdata;
        end else begin
            rdy = b0.pready; er = b0.pslverr; rd = b0.prdata;
        end
    endtask

    task automatic idle(input bit w3);
        drive(w3, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge hclk); #1;
    endtask

    // Starts at posedge+1; returns at posedge+1 after the completing edge.
    // acc is the number of access cycles observed (99 when pready never rose).
    task automatic xfer(input bit w3, input logic [2:0] sel, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int acc);
        logic        rdy;
        logic        e;
        logic [31:0] r;
        bit          done;
        done = 1'b0;
        acc  = 0;
        rd   = 'x;
        er   = 'x;
        drive(w3, sel, 1'b0, wr, a, d);
        @(posedge hclk); #1;
        drive(w3, sel, 1'b1, wr, a, d);
        while (!done && acc < 20) begin
            @(negedge hclk);
            acc++;
            sample(w3, rdy, e, r);
            if (rdy) begin
                rd   = r;
                er   = e;
                done = 1'b1;
            end
            @(posedge hclk); #1;
        end
        if (!done) acc = 99;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (b0.pready !== 1'b0) begin errors++; $display("FAIL reset_pready0 got %b want 0", b0.pready); end
        checks++; if (b0.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr0 got %b want 0", b0.pslverr); end
        checks++; if (b0.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata0 got %h want 0", b0.prdata); end
        checks++; if (b3.pready !== 1'b0) begin errors++; $display("FAIL reset_pready3 got %b want 0", b3.pready); end
        checks++; if (b3.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata3 got %h want 0", b3.prdata); end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int acc;
        xfer(1'b0, 3'b010, 1'b1, 32'h8, 32'hCAFE_0001, rd, er, acc);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b want 0", er); end
        checks++; if (acc !== 1) begin errors++; $display("FAIL basic_wr_lat got %0d want 1", acc); end
        xfer(1'b0, 3'b010, 1'b0, 32'h8, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL basic_rd_data got %h want cafe0001", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_err got %b want 0", er); end
        checks++; if (acc !== 1) begin errors++; $display("FAIL basic_rd_lat got %0d want 1", acc); end
        idle(1'b0);
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic er; int acc;
        xfer(1'b1, 3'b001, 1'b0, 32'h4, 32'h0, rd, er, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL wait_lat got %0d want 4", acc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wait_data got %h want 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wait_err got %b want 0", er); end
        idle(1'b1);
    endtask

    task automatic test_addr_err();
        logic [31:0] rd; logic er; int acc;
        xfer(1'b0, 3'b001, 1'b1, 32'h3, 32'h1234, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got %b want 1", er); end
        xfer(1'b0, 3'b001, 1'b1, 32'h40, 32'h5678, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", er); end
        xfer(1'b0, 3'b001, 1'b0, 32'h0, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_nowrite got %h want 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_err got %b want 0", er); end
        xfer(1'b0, 3'b010, 1'b0, 32'hA, 32'h0, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rd_misalign_err got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_err_data got %h want 0", rd); end
        idle(1'b0);
    endtask

    task automatic test_bad_sel();
        logic [31:0] rd; logic er; int acc;
        xfer(1'b0, 3'b011, 1'b1, 32'h8, 32'hDEAD_BEEF, rd, er, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL badsel_err got %b want 1", er); end
        xfer(1'b0, 3'b001, 1'b0, 32'h8, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL badsel_s0 got %h want 0", rd); end
        xfer(1'b0, 3'b010, 1'b0, 32'h8, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL badsel_s1 got %h want cafe0001", rd); end
        idle(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int acc;
        longint t0;
        t0 = $time;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 3'b100, 1'b1, 32'(i * 4), 32'h1000_00A0 + 32'(i), rd, er, acc);
            checks++; if (acc !== 1 || er !== 1'b0) begin errors++; $display("FAIL b2b_wr%0d lat %0d err %b want 1 0", i, acc, er); end
        end
        checks++; if (($time - t0) !== 64'd80) begin errors++; $display("FAIL b2b_time got %0d want 80", $time - t0); end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 3'b100, 1'b0, 32'(i * 4), 32'h0, rd, er, acc);
            checks++; if (rd !== 32'h1000_00A0 + 32'(i)) begin errors++; $display("FAIL b2b_rd%0d got %h want %h", i, rd, 32'h1000_00A0 + 32'(i)); end
        end
        xfer(1'b0, 3'b010, 1'b0, 32'h8, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL no_alias got %h want cafe0001", rd); end
        idle(1'b0);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int acc;
        xfer(1'b1, 3'b001, 1'b1, 32'hC, 32'h0000_0011, rd, er, acc);
        idle(1'b1);
        drive(1'b1, 3'b001, 1'b0, 1'b1, 32'hC, 32'h0000_0BAD);
        @(posedge hclk); #1;
        drive(1'b1, 3'b001, 1'b1, 1'b1, 32'hC, 32'h0000_0BAD);
        @(posedge hclk); #1;
        drive(1'b1, 3'b000, 1'b0, 1'b1, 32'hC, 32'h0000_0BAD);
        @(posedge hclk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            checks++; if (b3.pready !== 1'b0) begin errors++; $display("FAIL abort_pready%0d got %b want 0", i, b3.pready); end
        end
        @(posedge hclk); #1;
        xfer(1'b1, 3'b001, 1'b0, 32'hC, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL abort_data got %h want 11", rd); end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int acc;
        // Reset asserted mid-cycle during a ready read on the zero-wait bank.
        drive(1'b0, 3'b100, 1'b0, 1'b0, 32'h4, 32'h0);
        @(posedge hclk); #1;
        drive(1'b0, 3'b100, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge hclk);
        checks++; if (b0.prdata !== 32'h1000_00A1) begin errors++; $display("FAIL pre_rst_data got %h want 100000a1", b0.prdata); end
        #1 rst0_n = 1'b0;
        #1;
        checks++; if (b0.pready !== 1'b0) begin errors++; $display("FAIL rst_mid_pready got %b want 0", b0.pready); end
        checks++; if (b0.prdata !== 32'h0) begin errors++; $display("FAIL rst_mid_prdata got %h want 0", b0.prdata); end
        @(posedge hclk); #1;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        rst0_n = 1'b1;
        @(posedge hclk); #1;
        xfer(1'b0, 3'b100, 1'b0, 32'h4, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_clear_s2 got %h want 0", rd); end
        xfer(1'b0, 3'b010, 1'b0, 32'h8, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_clear_s1 got %h want 0", rd); end
        idle(1'b0);
        // Reset during a wait cycle of a write on the wait-state bank.
        xfer(1'b1, 3'b001, 1'b1, 32'h14, 32'h55, rd, er, acc);
        drive(1'b1, 3'b001, 1'b0, 1'b1, 32'h10, 32'h77);
        @(posedge hclk); #1;
        drive(1'b1, 3'b001, 1'b1, 1'b1, 32'h10, 32'h77);
        @(posedge hclk); #1;
        rst3_n = 1'b0;
        @(posedge hclk); #1;
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        rst3_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge hclk); #1;
        end
        xfer(1'b1, 3'b001, 1'b0, 32'h10, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0 || acc !== 4) begin errors++; $display("FAIL rst_inflight got %h lat %0d want 0 4", rd, acc); end
        xfer(1'b1, 3'b001, 1'b0, 32'h14, 32'h0, rd, er, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_clear3 got %h want 0", rd); end
        idle(1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge hclk); #1;
        @(posedge hclk);
        test_reset();
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge hclk); #1;
        test_basic();
        test_wait();
        test_addr_err();
        test_bad_sel();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
